// File: rtl/wakeup_select.sv
// wakeup_select: reservation-station entry tracking with source wakeup and
// lowest-index select. Free-slot and select outputs are derived from the
// registered state only, so a slot freed by issue is visible one cycle later.
module wakeup_select #(
  parameter int unsigned RS_ENTRIES = 8,
  parameter int unsigned NUM_FUS    = 4,
  parameter int unsigned NUM_COLS   = 4,
  localparam int unsigned RS_IDX_WIDTH = $clog2(RS_ENTRIES),
  localparam int unsigned LOC_WIDTH    = $clog2(NUM_FUS) + $clog2(NUM_COLS),
  localparam int unsigned NUM_LOCS     = NUM_FUS * NUM_COLS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  input  logic                    latency,
  input  logic                    src1_dp_en,
  input  logic                    src2_dp_en,
  input  logic [LOC_WIDTH-1:0]    src1_dp_loc,
  input  logic [LOC_WIDTH-1:0]    src2_dp_loc,
  input  logic [NUM_LOCS-1:0]     wb_valid,
  output logic                    entry_free,
  output logic [RS_IDX_WIDTH-1:0] entry_index,
  output logic                    issue_valid,
  output logic [RS_IDX_WIDTH-1:0] issue_index,
  output logic                    issue_latency,
  input  logic                    issue_ready
);

  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  logic [RS_ENTRIES-1:0] lat_q, lat_d;
  logic [RS_ENTRIES-1:0] p1_q, p1_d;
  logic [RS_ENTRIES-1:0] p2_q, p2_d;
  logic [LOC_WIDTH-1:0]  loc1_q [RS_ENTRIES];
  logic [LOC_WIDTH-1:0]  loc1_d [RS_ENTRIES];
  logic [LOC_WIDTH-1:0]  loc2_q [RS_ENTRIES];
  logic [LOC_WIDTH-1:0]  loc2_d [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] ready;

  assign ready = valid_q & ~p1_q & ~p2_q;

  // Lowest-numbered unoccupied slot; descending scan so the lowest hit wins.
  always_comb begin
    entry_free  = 1'b0;
    entry_index = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        entry_free  = 1'b1;
        entry_index = RS_IDX_WIDTH'(i);
      end
    end
  end

  // Lowest-numbered ready entry is offered for issue.
  always_comb begin
    issue_valid   = 1'b0;
    issue_index   = '0;
    issue_latency = 1'b0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_valid   = 1'b1;
        issue_index   = RS_IDX_WIDTH'(i);
        issue_latency = lat_q[i];
      end
    end
  end

  // Next state: wakeup, then issue clear, then allocation; flush overrides all.
  always_comb begin
    valid_d = valid_q;
    lat_d   = lat_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    loc1_d  = loc1_q;
    loc2_d  = loc2_q;

    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (valid_q[i]) begin
        if (p1_q[i] && wb_valid[loc1_q[i]]) p1_d[i] = 1'b0;
        if (p2_q[i] && wb_valid[loc2_q[i]]) p2_d[i] = 1'b0;
      end
    end

    if (issue_valid && issue_ready) valid_d[issue_index] = 1'b0;

    // The issuing slot is still valid, so entry_index never collides with it.
    if (dispatch_valid && entry_free) begin
      valid_d[entry_index] = 1'b1;
      lat_d[entry_index]   = latency;
      p1_d[entry_index]    = src1_dp_en && !wb_valid[src1_dp_loc];
      p2_d[entry_index]    = src2_dp_en && !wb_valid[src2_dp_loc];
      loc1_d[entry_index]  = src1_dp_loc;
      loc2_d[entry_index]  = src2_dp_loc;
    end

    if (flush) valid_d = '0;
  end

  // State registers; reset also zeroes the stored fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lat_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        loc1_q[i] <= '0;
        loc2_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      lat_q   <= lat_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      loc1_q  <= loc1_d;
      loc2_q  <= loc2_d;
    end
  end

  // Dispatch must not be presented while the station is full.
  assert property (@(posedge clk) disable iff (rst) !(dispatch_valid && !entry_free));

endmodule

// File: doc/wakeup_select.md
Name: wakeup_select

Overview:
- Reservation-station wakeup/select block at the Wakeup end of the Dispatch–Wakeup interface.
- Accepts dispatched instructions into RS_ENTRIES slots and tracks source dependencies by producer location {FU, column}.
- Clears dependencies on completion broadcasts from the functional units.
- Selects one ready entry per cycle for issue, and reports free-slot availability back to Dispatch.

Parameters:
RS_ENTRIES, 8, number of reservation-station entries (power of two)
NUM_FUS, 4, number of functional units (power of two)
NUM_COLS, 4, columns per FU in the dependency location space (power of two)
(derived) RS_IDX_WIDTH = clog2(RS_ENTRIES); LOC_WIDTH = clog2(NUM_FUS) + clog2(NUM_COLS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries
dispatch_valid  in  1  Dispatch presents an instruction this cycle
latency  in  1  latency class of dispatched instruction, carried to issue
src1_dp_en  in  1  src1 waits on an in-flight producer
src2_dp_en  in  1  src2 waits on an in-flight producer
src1_dp_loc  in  LOC_WIDTH  producer location {fu,col} for src1
src2_dp_loc  in  LOC_WIDTH  producer location {fu,col} for src2
wb_valid  in  NUM_FUS*NUM_COLS  completion broadcast; bit fu*NUM_COLS+col set = location completed
entry_free  out  1  at least one entry is unoccupied
entry_index  out  RS_IDX_WIDTH  index of lowest-numbered free entry
issue_valid  out  1  a ready entry is offered for issue
issue_index  out  RS_IDX_WIDTH  index of offered entry
issue_latency  out  1  stored latency of offered entry
issue_ready  in  1  FU accepts the offered entry

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Per-entry state: valid, lat, p1, p2 (pending flags), loc1, loc2.
- Reset: all valid=0, so entry_free=1, entry_index=0, issue_valid=0, issue_index=0, issue_latency=0.
- entry_free, entry_index: combinational from registered valid bits only.
  - A slot freed by issue this cycle becomes visible next cycle.
  - When full, entry_free=0 and entry_index=0.
- Allocation: on dispatch_valid && entry_free, the slot at entry_index is written at the next edge with valid=1, lat=latency, loc1/loc2 from inputs.
  - pN = srcN_dp_en && !wb_valid[srcN_dp_loc]: same-cycle broadcast bypass.
  - dispatch_valid with entry_free=0 is a protocol violation: write ignored, assertion fires.
- Wakeup: each cycle, for every valid entry with pN=1, if wb_valid[locN]=1 then pN clears at the next edge.
  - A single broadcast bit may wake any number of entries/sources.
  - loc is ignored when pN=0.
- Ready = valid && !p1 && !p2, computed from registered state.
  - An entry woken by a broadcast is ready one cycle after the broadcast.
  - An entry dispatched with both en=0 is ready the cycle after dispatch.
- Select: combinational. issue_valid = any ready entry; issue_index = lowest-index ready entry; issue_latency = its lat.
  - Outputs hold stable while issue_valid && !issue_ready, unless a lower-index entry becomes ready; in that case the offer switches to it (no starvation guarantee required).
- Issue: on issue_valid && issue_ready, valid of issue_index clears at the next edge.
- Simultaneous issue and dispatch: both take effect. Dispatch never targets the issuing slot, because that slot is still valid, so entry_index differs from it.
- flush: all valid clear at the next edge. Flush has priority over dispatch, issue and wakeup in the same cycle.
- rst mid-operation: identical to flush, plus all stored fields zeroed.
- No other state; no counters beyond combinational priority encoders.

Test Plan:
- Reset, then dispatch with src1_dp_en=src2_dp_en=0, latency=1 -> entry 0 written; next cycle issue_valid=1, issue_index=0, issue_latency=1; with issue_ready=1, entry_free=1 and entry_index=0 the following cycle.
- Dispatch into entry 0 with src1_dp_en=1, src1_dp_loc={fu=2,col=1}; pulse wb_valid bit 9 two cycles later -> issue_valid=0 until the cycle after the pulse, then issue_index=0.
- Dispatch with src2_dp_loc={1,3} while wb_valid bit 7 is set in the same cycle -> p2 stored 0; issue_valid=1 the next cycle.
- Fill all 8 entries with pending sources -> entry_free=0; drop dispatch_valid. Broadcast waking entries 5 and 2 -> issue_index=2 first, then 5; after issuing 2, entry_free=1 and entry_index=2.
- Full RS, issue_ready=0 for 3 cycles -> issue_index stable, nothing freed. Then assert issue_ready together with dispatch_valid the cycle after the free appears -> new instruction lands in the freed slot.
- Six valid entries with flush=1 asserted together with dispatch_valid and issue_ready -> next cycle all entries invalid, entry_free=1, entry_index=0, issue_valid=0.
